// File: rtl/uart_hex_shift_if.sv
// rtl/uart_hex_shift_if.sv - serial line, clear and display bundle for uart_hex_shift
//
// Groups the serial input, the clear strobe and every display/status output
// of uart_hex_shift so they travel as one port.
//   i_rxd          serial line, idle high, 8 data bits LSB first
//   i_clear        synchronous clear of the display buffer
//   o_data         display buffer, DIGITS nibbles
//   o_byte_valid   one-cycle pulse when a byte is accepted
//   o_frame_err    one-cycle pulse on a bad stop bit
//   o_parity_err   one-cycle pulse on a bad parity bit
//   o_anodes       one-hot active-high digit enable
//   o_seg          {A,B,C,D,E,F,G,DP}, active-high
// master drives the line and clear; slave is the receiver/display.

interface uart_hex_shift_if #(
    parameter int DIGITS = 4
);
    logic                  i_rxd;
    logic                  i_clear;
    logic [DIGITS*4-1:0]   o_data;
    logic                  o_byte_valid;
    logic                  o_frame_err;
    logic                  o_parity_err;
    logic [DIGITS-1:0]     o_anodes;
    logic [7:0]            o_seg;

    modport master (
        output i_rxd,
        output i_clear,
        input  o_data,
        input  o_byte_valid,
        input  o_frame_err,
        input  o_parity_err,
        input  o_anodes,
        input  o_seg
    );

    modport slave (
        input  i_rxd,
        input  i_clear,
        output o_data,
        output o_byte_valid,
        output o_frame_err,
        output o_parity_err,
        output o_anodes,
        output o_seg
    );
endinterface

// File: rtl/uart_hex_shift.sv
// rtl/uart_hex_shift.sv - oversampling UART receiver feeding a shifting hex display
//
// Receives 8-bit frames (optional even/odd parity, one stop bit) by
// oversampling the line from the system clock, shifts every accepted byte
// into a DIGITS-nibble display buffer and scans that buffer onto a
// multiplexed seven-segment display.
//   clk   system clock, all logic on the rising edge
//   rst   asynchronous active-high reset
//   bus   uart_hex_shift_if.slave: i_rxd, i_clear in; o_data, o_byte_valid,
//         o_frame_err, o_parity_err, o_anodes, o_seg out

module uart_hex_shift #(
    parameter int                  CLK_HZ     = 48_000_000,
    parameter int                  BAUD       = 38400,
    parameter int                  OVERSAMPLE = 16,
    parameter int                  DIGITS     = 4,
    parameter int                  PARITY     = 0,
    parameter int                  SCAN_DIV   = 48000,
    parameter logic [DIGITS*4-1:0] INIT       = 16'hAA00
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_hex_shift_if.slave       bus
);

    localparam int TICK_DIV = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCW      = $clog2(OVERSAMPLE);
    localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DW       = $clog2(DIGITS);
    localparam int DATA_W   = DIGITS * 4;

    localparam logic [TW-1:0]  TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [SCW-1:0] SC_MID     = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SC_LAST    = SCW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0]  SCAN_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [DW-1:0]  DIGIT_LAST = DW'(DIGITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP,
        S_BREAK
    } state_t;

    function automatic logic [7:0] f_glyph(input logic [3:0] n);
        logic [7:0] g;
        case (n)
            4'h0: g = 8'hFC;
            4'h1: g = 8'h60;
            4'h2: g = 8'hDA;
            4'h3: g = 8'hF2;
            4'h4: g = 8'h66;
            4'h5: g = 8'hB6;
            4'h6: g = 8'hBE;
            4'h7: g = 8'hE0;
            4'h8: g = 8'hFE;
            4'h9: g = 8'hF6;
            4'hA: g = 8'hEE;
            4'hB: g = 8'h3E;
            4'hC: g = 8'h9C;
            4'hD: g = 8'h7A;
            4'hE: g = 8'h9E;
            default: g = 8'h8E;
        endcase
        return g;
    endfunction

    // ------------------------------------------------------------------
    // Tick divider: free-running, never aligned to the line, so start
    // detection carries up to one tick of jitter.
    // ------------------------------------------------------------------
    logic [TW-1:0] r_tick_cnt;
    logic          r_tick;
    logic          w_tick;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= '0;
        end else if (w_tick) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + TW'(1);
        end
    end

    // Combinational tick: high in the cycle where the counter sits at its
    // last value, which is the edge the receiver acts on.
    always_comb begin
        r_tick = w_tick;
    end

    // ------------------------------------------------------------------
    // Two-flop synchroniser; idles high so reset never looks like a start.
    // ------------------------------------------------------------------
    logic r_rx_meta;
    logic r_rx_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= bus.i_rxd;
            r_rx_sync <= r_rx_meta;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    state_t         r_state;
    state_t         w_state_next;
    logic [SCW-1:0] r_sc;
    logic [SCW-1:0] w_sc_next;
    logic [2:0]     r_bit_idx;
    logic [2:0]     w_bit_idx_next;
    logic [7:0]     r_shift;
    logic [7:0]     w_shift_next;
    logic           r_par_bit;
    logic           w_par_bit_next;
    logic           w_accept;
    logic           w_frame_err;
    logic           w_parity_err;
    logic           w_par_bad;

    // Parity bit is XORed with the data so even mode expects 0, odd mode 1.
    always_comb begin
        w_par_bad = 1'b0;
        if (PARITY == 1) begin
            w_par_bad = (^r_shift) ^ r_par_bit;
        end else if (PARITY == 2) begin
            w_par_bad = ~((^r_shift) ^ r_par_bit);
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_sc_next      = r_sc;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        w_par_bit_next = r_par_bit;
        w_accept       = 1'b0;
        w_frame_err    = 1'b0;
        w_parity_err   = 1'b0;

        if (r_tick) begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_sync) begin
                        w_state_next = S_START;
                        w_sc_next    = '0;
                    end
                end

                // Re-check the line half a bit in; a high line here was a glitch.
                S_START: begin
                    if (r_sc == SC_MID) begin
                        if (r_rx_sync) begin
                            w_state_next = S_IDLE;
                        end else begin
                            w_state_next   = S_DATA;
                            w_sc_next      = '0;
                            w_bit_idx_next = 3'd0;
                        end
                    end else begin
                        w_sc_next = r_sc + SCW'(1);
                    end
                end

                S_DATA: begin
                    if (r_sc == SC_LAST) begin
                        w_sc_next               = '0;
                        w_shift_next[r_bit_idx] = r_rx_sync;
                        if (r_bit_idx == 3'd7) begin
                            w_state_next = (PARITY != 0) ? S_PAR : S_STOP;
                        end else begin
                            w_bit_idx_next = r_bit_idx + 3'd1;
                        end
                    end else begin
                        w_sc_next = r_sc + SCW'(1);
                    end
                end

                S_PAR: begin
                    if (r_sc == SC_LAST) begin
                        w_sc_next      = '0;
                        w_par_bit_next = r_rx_sync;
                        w_state_next   = S_STOP;
                    end else begin
                        w_sc_next = r_sc + SCW'(1);
                    end
                end

                // Framing error wins over parity: a broken frame says nothing
                // trustworthy about its parity bit.
                S_STOP: begin
                    if (r_sc == SC_LAST) begin
                        w_sc_next = '0;
                        if (!r_rx_sync) begin
                            w_frame_err  = 1'b1;
                            w_state_next = S_BREAK;
                        end else if (w_par_bad) begin
                            w_parity_err = 1'b1;
                            w_state_next = S_IDLE;
                        end else begin
                            w_accept     = 1'b1;
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_sc_next = r_sc + SCW'(1);
                    end
                end

                // Hold off until the line returns high so a stuck-low line
                // does not read as an endless run of start bits.
                S_BREAK: begin
                    if (r_rx_sync) begin
                        w_state_next = S_IDLE;
                    end
                end

                default: begin
                    w_state_next = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_sc      <= '0;
            r_bit_idx <= 3'd0;
            r_shift   <= 8'd0;
            r_par_bit <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_sc      <= w_sc_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
            r_par_bit <= w_par_bit_next;
        end
    end

    // ------------------------------------------------------------------
    // Display buffer and status pulses. Clear beats a same-cycle accept,
    // and the byte it displaces is not reported.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_data;
    logic              r_byte_valid;
    logic              r_frame_err;
    logic              r_parity_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= INIT;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
        end else begin
            r_byte_valid <= w_accept && !bus.i_clear;
            r_frame_err  <= w_frame_err;
            r_parity_err <= w_parity_err;
            if (bus.i_clear) begin
                r_data <= '0;
            end else if (w_accept) begin
                r_data <= {r_data[DATA_W-9:0], r_shift};
            end
        end
    end

    // ------------------------------------------------------------------
    // Display scan. Anodes and segments are both loaded from the digit
    // index of the coming cycle so they always switch together; segments
    // also follow data changes on the current digit.
    // ------------------------------------------------------------------
    logic [SW-1:0] r_scan_cnt;
    logic [DW-1:0] r_digit;
    logic [DW-1:0] w_digit_next;
    logic          w_scan_wrap;
    logic [3:0]    w_nibble;
    logic [DIGITS-1:0] r_anodes;
    logic [7:0]    r_seg;

    assign w_scan_wrap = (r_scan_cnt == SCAN_LAST);

    always_comb begin
        w_digit_next = r_digit;
        if (w_scan_wrap) begin
            w_digit_next = (r_digit == DIGIT_LAST) ? '0 : r_digit + DW'(1);
        end
    end

    assign w_nibble = r_data[w_digit_next*4 +: 4];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= '0;
            r_anodes   <= DIGITS'(1);
            r_seg      <= f_glyph(INIT[3:0]);
        end else begin
            r_scan_cnt <= w_scan_wrap ? '0 : r_scan_cnt + SW'(1);
            r_digit    <= w_digit_next;
            r_anodes   <= DIGITS'(1) << w_digit_next;
            r_seg      <= f_glyph(w_nibble);
        end
    end

    assign bus.o_data       = r_data;
    assign bus.o_byte_valid = r_byte_valid;
    assign bus.o_frame_err  = r_frame_err;
    assign bus.o_parity_err = r_parity_err;
    assign bus.o_anodes     = r_anodes;
    assign bus.o_seg        = r_seg;

endmodule

// File: tb/tb_uart_hex_shift.sv
// tb/tb_uart_hex_shift.sv - directed self-checking bench for uart_hex_shift

module tb_uart_hex_shift;

    localparam int CLK_HZ   = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int OS       = 16;
    localparam int SCAN_DIV = 100;
    localparam int TICK     = CLK_HZ / (BAUD * OS);  // 10 clk
    localparam int BIT      = TICK * OS;             // 160 clk

    logic clk;
    logic rst;
    int   cyc;
    int   n_vec;
    int   n_bad;
    int   bv0, fe0, pe0, bv1, fe1, pe1;

    uart_hex_shift_if #(.DIGITS(4)) bus0 ();
    uart_hex_shift_if #(.DIGITS(4)) bus1 ();

    uart_hex_shift #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DIGITS(4),
        .PARITY(0), .SCAN_DIV(SCAN_DIV), .INIT(16'hAA00)
    ) dut0 (
        .clk(clk),
        .rst(rst),
        .bus(bus0)
    );

    uart_hex_shift #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OVERSAMPLE(OS), .DIGITS(4),
        .PARITY(1), .SCAN_DIV(SCAN_DIV), .INIT(16'hAA00)
    ) dut1 (
        .clk(clk),
        .rst(rst),
        .bus(bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter aligned with the DUT tick divider: edge k after reset
    // release leaves cyc == k, and ticks fall on multiples of TICK.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (bus0.o_byte_valid === 1'b1) bv0 = bv0 + 1;
        if (bus0.o_frame_err  === 1'b1) fe0 = fe0 + 1;
        if (bus0.o_parity_err === 1'b1) pe0 = pe0 + 1;
        if (bus1.o_byte_valid === 1'b1) bv1 = bv1 + 1;
        if (bus1.o_frame_err  === 1'b1) fe1 = fe1 + 1;
        if (bus1.o_parity_err === 1'b1) pe1 = pe1 + 1;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int which, input logic v);
        if (which == 0) bus0.i_rxd = v;
        else            bus1.i_rxd = v;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        hold(3);
        rst = 1'b0;
    endtask

    task automatic send_frame(input int which, input logic [7:0] b,
                              input bit use_par, input logic par,
                              input logic stop, input int stop_bits);
        drive_line(which, 1'b0);
        hold(BIT);
        for (int i = 0; i < 8; i++) begin
            drive_line(which, b[i]);
            hold(BIT);
        end
        if (use_par) begin
            drive_line(which, par);
            hold(BIT);
        end
        drive_line(which, stop);
        hold(BIT * stop_bits);
        drive_line(which, 1'b1);
    endtask

    task automatic test_reset();
        do_reset();
        hold(2);
        n_vec++;
        if (bus0.o_data !== 16'hAA00) begin
            n_bad++; $display("FAIL reset_data: got %h want aa00", bus0.o_data);
        end
        n_vec++;
        if ({bus0.o_byte_valid, bus0.o_frame_err, bus0.o_parity_err} !== 3'b000) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 000",
                              {bus0.o_byte_valid, bus0.o_frame_err, bus0.o_parity_err});
        end
        n_vec++;
        if (bus0.o_anodes !== 4'b0001) begin
            n_bad++; $display("FAIL reset_anodes: got %b want 0001", bus0.o_anodes);
        end
        n_vec++;
        if (bus0.o_seg !== 8'hFC) begin
            n_bad++; $display("FAIL reset_seg: got %h want fc", bus0.o_seg);
        end
        n_vec++;
        if (bus1.o_data !== 16'hAA00) begin
            n_bad++; $display("FAIL reset_data_par: got %h want aa00", bus1.o_data);
        end
    endtask

    task automatic test_back_to_back();
        int s_bv;
        int k;
        do_reset();
        hold(20);
        s_bv = bv0;
        send_frame(0, 8'h3C, 0, 1'b0, 1'b1, 1);
        hold(2);
        n_vec++;
        if (bus0.o_data !== 16'h003C) begin
            n_bad++; $display("FAIL b2b_first_data: got %h want 003c", bus0.o_data);
        end
        n_vec++;
        if (bv0 - s_bv !== 1) begin
            n_bad++; $display("FAIL b2b_first_pulse: got %0d want 1", bv0 - s_bv);
        end
        // second start bit straight after the first stop bit ends
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1);
        hold(2);
        n_vec++;
        if (bus0.o_data !== 16'h3CA5) begin
            n_bad++; $display("FAIL b2b_second_data: got %h want 3ca5", bus0.o_data);
        end
        n_vec++;
        if (bv0 - s_bv !== 2) begin
            n_bad++; $display("FAIL b2b_pulse_count: got %0d want 2", bv0 - s_bv);
        end
        k = 0;
        while (bus0.o_anodes !== 4'b0001 && k < 5 * SCAN_DIV) begin
            hold(1);
            k++;
        end
        n_vec++;
        if (bus0.o_anodes !== 4'b0001 || bus0.o_seg !== 8'hB6) begin
            n_bad++; $display("FAIL b2b_digit0_glyph: anodes %b seg %h want 0001 b6",
                              bus0.o_anodes, bus0.o_seg);
        end
    endtask

    task automatic test_glitch();
        int s_bv, s_fe;
        do_reset();
        hold(20);
        s_bv = bv0; s_fe = fe0;
        drive_line(0, 1'b0);
        hold(4 * TICK);
        drive_line(0, 1'b1);
        hold(3 * BIT);
        n_vec++;
        if (bv0 - s_bv !== 0 || fe0 - s_fe !== 0) begin
            n_bad++; $display("FAIL glitch_pulses: got bv %0d fe %0d want 0 0",
                              bv0 - s_bv, fe0 - s_fe);
        end
        n_vec++;
        if (bus0.o_data !== 16'hAA00) begin
            n_bad++; $display("FAIL glitch_data: got %h want aa00", bus0.o_data);
        end
        send_frame(0, 8'h7E, 0, 1'b0, 1'b1, 1);
        hold(2);
        n_vec++;
        if (bus0.o_data !== 16'h007E) begin
            n_bad++; $display("FAIL glitch_then_7e: got %h want 007e", bus0.o_data);
        end
    endtask

    task automatic test_frame_err();
        int s_bv, s_fe, s_pe;
        do_reset();
        hold(20);
        s_bv = bv0; s_fe = fe0; s_pe = pe0;
        send_frame(0, 8'h55, 0, 1'b0, 1'b0, 3);
        n_vec++;
        if (fe0 - s_fe !== 1) begin
            n_bad++; $display("FAIL ferr_pulse: got %0d want 1", fe0 - s_fe);
        end
        n_vec++;
        if (bv0 - s_bv !== 0 || pe0 - s_pe !== 0) begin
            n_bad++; $display("FAIL ferr_other_pulses: got bv %0d pe %0d want 0 0",
                              bv0 - s_bv, pe0 - s_pe);
        end
        n_vec++;
        if (bus0.o_data !== 16'hAA00) begin
            n_bad++; $display("FAIL ferr_data: got %h want aa00", bus0.o_data);
        end
        hold(BIT);
        send_frame(0, 8'h12, 0, 1'b0, 1'b1, 1);
        hold(2);
        n_vec++;
        if (bus0.o_data !== 16'h0012 || bv0 - s_bv !== 1) begin
            n_bad++; $display("FAIL ferr_recover: got %h bv %0d want 0012 1",
                              bus0.o_data, bv0 - s_bv);
        end
        n_vec++;
        if (fe0 - s_fe !== 1) begin
            n_bad++; $display("FAIL ferr_no_retrigger: got %0d want 1", fe0 - s_fe);
        end
    endtask

    task automatic test_parity();
        int s_bv, s_pe;
        do_reset();
        hold(20);
        s_bv = bv1; s_pe = pe1;
        send_frame(1, 8'h01, 1, 1'b0, 1'b1, 1);
        hold(2);
        n_vec++;
        if (pe1 - s_pe !== 1 || bv1 - s_bv !== 0) begin
            n_bad++; $display("FAIL par_bad_pulses: got pe %0d bv %0d want 1 0",
                              pe1 - s_pe, bv1 - s_bv);
        end
        n_vec++;
        if (bus1.o_data !== 16'hAA00) begin
            n_bad++; $display("FAIL par_bad_data: got %h want aa00", bus1.o_data);
        end
        send_frame(1, 8'h01, 1, 1'b1, 1'b1, 1);
        hold(2);
        n_vec++;
        if (bus1.o_data !== 16'h0001 || bv1 - s_bv !== 1) begin
            n_bad++; $display("FAIL par_good: got %h bv %0d want 0001 1",
                              bus1.o_data, bv1 - s_bv);
        end
        n_vec++;
        if (pe1 - s_pe !== 1 || fe1 !== 0) begin
            n_bad++; $display("FAIL par_good_no_err: got pe %0d fe %0d want 1 0",
                              pe1 - s_pe, fe1);
        end
    endtask

    task automatic test_clear_collision();
        int s_bv;
        do_reset();
        while (cyc == 0 || (cyc % TICK) != 0) hold(1);
        s_bv = bv0;
        // line falls just after tick edge E0; stop sample lands on E0+1530
        fork
            send_frame(0, 8'h99, 0, 1'b0, 1'b1, 1);
            begin
                hold(1529);
                bus0.i_clear = 1'b1;
                hold(1);
                bus0.i_clear = 1'b0;
            end
        join
        hold(2);
        n_vec++;
        if (bus0.o_data !== 16'h0000) begin
            n_bad++; $display("FAIL clear_data: got %h want 0000", bus0.o_data);
        end
        n_vec++;
        if (bv0 - s_bv !== 0) begin
            n_bad++; $display("FAIL clear_no_valid: got %0d want 0", bv0 - s_bv);
        end
    endtask

    task automatic test_reset_mid_frame();
        int s_bv, s_fe, s_pe;
        s_bv = bv0; s_fe = fe0; s_pe = pe0;
        drive_line(0, 1'b0);
        hold(BIT);
        drive_line(0, 1'b1);
        hold(BIT);
        drive_line(0, 1'b0);
        hold(BIT + BIT / 2);
        rst = 1'b1;
        hold(5);
        drive_line(0, 1'b1);
        rst = 1'b0;
        hold(12 * BIT);
        n_vec++;
        if (bus0.o_data !== 16'hAA00) begin
            n_bad++; $display("FAIL rst_mid_data: got %h want aa00", bus0.o_data);
        end
        n_vec++;
        if (bv0 - s_bv !== 0 || fe0 - s_fe !== 0 || pe0 - s_pe !== 0) begin
            n_bad++; $display("FAIL rst_mid_pulses: got bv %0d fe %0d pe %0d want 0 0 0",
                              bv0 - s_bv, fe0 - s_fe, pe0 - s_pe);
        end
    endtask

    task automatic test_scan();
        do_reset();
        hold(99);
        n_vec++;
        if (bus0.o_anodes !== 4'b0001 || bus0.o_seg !== 8'hFC) begin
            n_bad++; $display("FAIL scan_99: anodes %b seg %h want 0001 fc",
                              bus0.o_anodes, bus0.o_seg);
        end
        hold(1);
        n_vec++;
        if (bus0.o_anodes !== 4'b0010 || bus0.o_seg !== 8'hFC) begin
            n_bad++; $display("FAIL scan_100: anodes %b seg %h want 0010 fc",
                              bus0.o_anodes, bus0.o_seg);
        end
        hold(SCAN_DIV);
        n_vec++;
        if (bus0.o_anodes !== 4'b0100 || bus0.o_seg !== 8'hEE) begin
            n_bad++; $display("FAIL scan_200: anodes %b seg %h want 0100 ee",
                              bus0.o_anodes, bus0.o_seg);
        end
        hold(SCAN_DIV);
        n_vec++;
        if (bus0.o_anodes !== 4'b1000 || bus0.o_seg !== 8'hEE) begin
            n_bad++; $display("FAIL scan_300: anodes %b seg %h want 1000 ee",
                              bus0.o_anodes, bus0.o_seg);
        end
        hold(SCAN_DIV);
        n_vec++;
        if (bus0.o_anodes !== 4'b0001 || bus0.o_seg !== 8'hFC) begin
            n_bad++; $display("FAIL scan_wrap: anodes %b seg %h want 0001 fc",
                              bus0.o_anodes, bus0.o_seg);
        end
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        bv0 = 0; fe0 = 0; pe0 = 0; bv1 = 0; fe1 = 0; pe1 = 0;
        rst = 1'b1;
        bus0.i_rxd = 1'b1; bus0.i_clear = 1'b0;
        bus1.i_rxd = 1'b1; bus1.i_clear = 1'b0;
        hold(2);
        test_reset();
        test_scan();
        test_back_to_back();
        test_glitch();
        test_frame_err();
        test_parity();
        test_clear_collision();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_hex_shift.md
# uart_hex_shift

Single-clock UART receiver and N-digit hex display controller. Replaces the divided-clock receiver and fixed 16-bit display path. Oversamples the serial line from the system clock and shifts each accepted byte into a DIGITS-nibble display register. Detects start glitches, framing errors and optional parity errors, and drives a time-multiplexed seven-segment display directly.

## Interface
- `CLK_HZ`, 48_000_000, system clock frequency.
- `BAUD`, 38400, line rate.
- `OVERSAMPLE`, 16, ticks per bit; must be even and ≥ 8.
- `DIGITS`, 4, display nibbles; must be even and ≥ 2.
- `PARITY`, 0, 0 = none, 1 = even, 2 = odd.
- `SCAN_DIV`, 48000, clk cycles per digit during display scan.
- `INIT`, 16'hAA00, reset value of `data` (DIGITS*4 bits).

- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rxd` in 1: serial input, idle high, 8 data bits LSB first.
- `clear` in 1: synchronous clear of `data` to 0.
- `data` out DIGITS*4: display buffer.
- `byte_valid` out 1: one-cycle pulse when a byte is accepted.
- `frame_err` out 1: one-cycle pulse when the stop bit is bad.
- `parity_err` out 1: one-cycle pulse when parity is bad.
- `anodes` out DIGITS: one-hot active-high digit enable.
- `seg` out 8: {A,B,C,D,E,F,G,DP}, active-high.

## Operation
- Tick divider:
  - Divisor is TICK_DIV = CLK_HZ/(BAUD*OVERSAMPLE), integer floor (78 at defaults).
  - `tick` is high for one cycle when the counter equals TICK_DIV-1; the counter then wraps to 0.
  - The counter free-runs and is never resynchronised to the line.
- Input synchroniser: `rxd` passes through 2 flops, both reset to 1. All sampling uses the synchronised value.
- FSM states: IDLE, START, DATA, PAR, STOP, BREAK. All transitions happen on `tick` cycles only. The sample counter `sc` counts ticks.
  - IDLE: synchronised rxd = 0 → START, with `sc` = 0.
  - START: at `sc` = OVERSAMPLE/2-1, sample the line.
    - Line = 1 (glitch) → IDLE.
    - Line = 0 → DATA, with `sc` = 0 and bit index = 0.
  - DATA: at `sc` = OVERSAMPLE-1, shift the sample into the byte at the bit index and reset `sc`.
    - After bit 7 → PAR if PARITY≠0, else STOP.
  - PAR: at `sc` = OVERSAMPLE-1, sample the parity bit → STOP.
  - STOP: at `sc` = OVERSAMPLE-1, sample the stop bit.
    - Stop bit = 0: pulse `frame_err` → BREAK. The byte is discarded and parity is not reported.
    - Stop bit = 1 and parity bad: pulse `parity_err` → IDLE. The byte is discarded.
    - Otherwise accept the byte → IDLE.
  - BREAK: wait for synchronised rxd = 1 → IDLE. This prevents a held-low line from retriggering.
- Parity check: even mode requires XOR(data bits, parity bit) = 0; odd mode requires it = 1.
- Accept:
  - `data` ← {data[DIGITS*4-9:0], byte}.
  - `byte_valid` pulses in the same cycle `data` updates.
- `clear` sets `data` to 0 and has priority over an accept in the same cycle. In that case the byte is lost and `byte_valid` stays 0.
- Display scan:
  - A counter of 0..SCAN_DIV-1 advances the digit index 0..DIGITS-1 with wrap.
  - `anodes` = 1<<index.
  - Digit 0 displays data[3:0].
  - `seg` shows the hex glyph of the selected nibble, with DP = 0.
  - Glyphs: 0 = FC, 1 = 60, 2 = DA, 3 = F2, 4 = 66, 5 = B6, 6 = BE, 7 = E0, 8 = FE, 9 = F6, A = EE, b = 3E, C = 9C, d = 7A, E = 9E, F = 8E.
  - `anodes` and `seg` are registered and change in the same cycle.

## Timing
- Reset values:
  - FSM = IDLE, all counters = 0.
  - `data` = INIT.
  - `byte_valid` = `frame_err` = `parity_err` = 0.
  - `anodes` = 1 (digit 0).
  - `seg` = glyph of INIT[3:0] (FC at defaults).
- Reset mid-frame aborts the frame. No pulse is emitted and `data` keeps its reset value.
- Start detection latency: falling edge of the line plus 2 clk (synchroniser), plus up to 1 tick.
- Acceptance point: mid-stop-bit, 9.5 bit times after start detection (10.5 with parity).
- `data`, `byte_valid`, `frame_err` and `parity_err` are registered at the edge where the stop-sample `tick` is high. They are visible the following cycle.
- Pulses are exactly 1 clk wide. At most one of the three pulses is active per frame.
- Back-to-back frames: a start bit immediately after the stop sample is detected with no lost byte.
- After `data` changes, the display reflects it within at most one digit period (SCAN_DIV cycles).

## Test plan
- Default parameters, send 0x3C in 8N1 → `byte_valid` pulses once and `data` goes AA00 → 003C. Then send 0xA5 → `data` = 3CA5.
- Drive `rxd` low for 4 ticks then high → no state leaves IDLE after START, and no pulses. Then send 0x7E → `data` = 007E.
- Send 0x55 with stop bit = 0 held low for 3 bit times → `frame_err` pulses once and `data` is unchanged. No further activity until the line goes high, then 0x12 is accepted.
- PARITY = 1, send 0x01 with parity bit 0 → `parity_err` pulses and `data` is unchanged. Send 0x01 with parity bit 1 → accepted.
- Assert `clear` on the exact acceptance cycle of 0x99 → `data` = 0000 and no `byte_valid`. Assert `rst` mid-data-bit → `data` = AA00 and no pulses.
- After reset → `anodes` = 0001 and `seg` = FC. After SCAN_DIV cycles → `anodes` = 0010 and `seg` = FC. After 4·SCAN_DIV cycles → `anodes` wraps to 0001.
